// File: rtl/sqrt_arbiter.sv
//----------------------------------------------------------------------------
// sqrt_arbiter
//   Shares one pipelined square-root core (fixed latency, no backpressure,
//   no sideband) among NUM_REQ requesters. Grants round-robin, forwards the
//   winning operand to the core and records the requester ID in a tag FIFO.
//   Results come back in issue order, each paired with its tag.
//   After reset the core pipeline still holds stale data. The block therefore
//   spends SQRT_LATENCY cycles in FLUSH and ignores any core output it sees
//   during that time.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   req_tvalid/tdata  per-requester operand stream (tdata packed, IN_W each)
//   req_tready        per-requester accept, one-hot or zero
//   sqrt_in_t*        operand stream to the core
//   sqrt_out_t*       result stream from the core
//   res_t*            result pulse with requester index (no backpressure)
//   outstanding       issued results not yet returned
//   busy              flushing, or results outstanding
//   err_orphan        sticky: core result seen in RUN with no tag pending
//----------------------------------------------------------------------------
module sqrt_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int IN_W            = 48,
  parameter int OUT_W           = 24,
  parameter int SQRT_LATENCY    = 20,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_tvalid,
  input  logic [NUM_REQ*IN_W-1:0] req_tdata,
  output logic [NUM_REQ-1:0]      req_tready,
  output logic                    sqrt_in_tvalid,
  output logic [IN_W-1:0]         sqrt_in_tdata,
  input  logic                    sqrt_out_tvalid,
  input  logic [OUT_W-1:0]        sqrt_out_tdata,
  output logic                    res_tvalid,
  output logic [OUT_W-1:0]        res_tdata,
  output logic [1:0]              res_tid,
  output logic [5:0]              outstanding,
  output logic                    busy,
  output logic                    err_orphan
);

  localparam int              PTR_W   = $clog2(MAX_OUTSTANDING);
  localparam int              FC_W    = $clog2(SQRT_LATENCY + 1);
  localparam logic [5:0]      MAX_CNT = 6'(MAX_OUTSTANDING);

  typedef enum logic {ST_FLUSH, ST_RUN} state_t;

  state_t               state_q, state_d;
  logic [FC_W-1:0]      flush_cnt_q, flush_cnt_d;
  logic [1:0]           last_grant_q, last_grant_d;
  logic [5:0]           count_q, count_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 sqrt_in_tvalid_q, sqrt_in_tvalid_d;
  logic [IN_W-1:0]      sqrt_in_tdata_q, sqrt_in_tdata_d;
  logic                 res_tvalid_q, res_tvalid_d;
  logic [OUT_W-1:0]     res_tdata_q, res_tdata_d;
  logic [1:0]           res_tid_q, res_tid_d;
  logic                 err_orphan_q, err_orphan_d;

  logic [1:0]           tag_mem [MAX_OUTSTANDING];

  logic [3:0]           vld4;
  logic [1:0]           rr_idx;
  logic [1:0]           grant_id;
  logic [NUM_REQ-1:0]   grant;
  logic                 push, pop, orphan;
  logic [IN_W-1:0]      op_sel;

  // Stage 0: round-robin arbitration (combinational). Occupancy is the
  // registered count, so a pop in this cycle does not free a slot until next.
  assign vld4 = 4'(req_tvalid);

  always_comb begin
    push     = 1'b0;
    grant_id = last_grant_q;
    rr_idx   = '0;
    if (state_q == ST_RUN && count_q < MAX_CNT) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        rr_idx = 2'((int'(last_grant_q) + k) % NUM_REQ);
        if (!push && vld4[rr_idx]) begin
          push     = 1'b1;
          grant_id = rr_idx;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = push && (grant_id == 2'(i));
    end
  end

  assign req_tready = grant;
  assign op_sel     = req_tdata[int'(grant_id)*IN_W +: IN_W];

  // Core results are only meaningful in RUN; during FLUSH they are stale.
  assign pop    = sqrt_out_tvalid && (state_q == ST_RUN) && (count_q != 6'd0);
  assign orphan = sqrt_out_tvalid && (state_q == ST_RUN) && (count_q == 6'd0);

  // Next-state computation for the registered stage
  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    last_grant_d     = push ? grant_id : last_grant_q;
    wr_ptr_d         = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d         = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    sqrt_in_tvalid_d = push;
    sqrt_in_tdata_d  = push ? op_sel : sqrt_in_tdata_q;
    res_tvalid_d     = pop;
    res_tdata_d      = pop ? sqrt_out_tdata : res_tdata_q;
    res_tid_d        = pop ? tag_mem[rd_ptr_q] : res_tid_q;
    err_orphan_d     = err_orphan_q | orphan;

    case ({push, pop})
      2'b10:   count_d = count_q + 6'd1;
      2'b01:   count_d = count_q - 6'd1;
      default: count_d = count_q;
    endcase

    if (state_q == ST_FLUSH) begin
      flush_cnt_d = (flush_cnt_q != '0) ? flush_cnt_q - 1'b1 : '0;
      if (flush_cnt_q <= FC_W'(1)) state_d = ST_RUN;
    end
  end

  // Stage 1: issue/return registers (core input, result output, FIFO control)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_FLUSH;
      flush_cnt_q      <= FC_W'(SQRT_LATENCY);
      last_grant_q     <= 2'(NUM_REQ - 1);
      count_q          <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      sqrt_in_tvalid_q <= 1'b0;
      sqrt_in_tdata_q  <= '0;
      res_tvalid_q     <= 1'b0;
      res_tdata_q      <= '0;
      res_tid_q        <= '0;
      err_orphan_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      last_grant_q     <= last_grant_d;
      count_q          <= count_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      sqrt_in_tvalid_q <= sqrt_in_tvalid_d;
      sqrt_in_tdata_q  <= sqrt_in_tdata_d;
      res_tvalid_q     <= res_tvalid_d;
      res_tdata_q      <= res_tdata_d;
      res_tid_q        <= res_tid_d;
      err_orphan_q     <= err_orphan_d;
    end
  end

  // Tag storage: contents are only meaningful between push and pop.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_q] <= grant_id;
  end

  assign sqrt_in_tvalid = sqrt_in_tvalid_q;
  assign sqrt_in_tdata  = sqrt_in_tdata_q;
  assign res_tvalid     = res_tvalid_q;
  assign res_tdata      = res_tdata_q;
  assign res_tid        = res_tid_q;
  assign outstanding    = count_q;
  assign busy           = (state_q == ST_FLUSH) || (count_q != 6'd0);
  assign err_orphan     = err_orphan_q;

endmodule

// File: tb/tb_sqrt_arbiter.sv
`timescale 1ns/1ps
module tb_sqrt_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_tvalid;
  logic [95:0] req_tdata;
  logic [1:0]  req_tready;
  logic        sqrt_in_tvalid;
  logic [47:0] sqrt_in_tdata;
  logic        sqrt_out_tvalid = 1'b0;
  logic [23:0] sqrt_out_tdata  = '0;
  logic        res_tvalid;
  logic [23:0] res_tdata;
  logic [1:0]  res_tid;
  logic [5:0]  outstanding;
  logic        busy;
  logic        err_orphan;

  sqrt_arbiter #(
    .NUM_REQ(2), .IN_W(48), .OUT_W(24), .SQRT_LATENCY(20), .MAX_OUTSTANDING(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_tvalid(req_tvalid), .req_tdata(req_tdata), .req_tready(req_tready),
    .sqrt_in_tvalid(sqrt_in_tvalid), .sqrt_in_tdata(sqrt_in_tdata),
    .sqrt_out_tvalid(sqrt_out_tvalid), .sqrt_out_tdata(sqrt_out_tdata),
    .res_tvalid(res_tvalid), .res_tdata(res_tdata), .res_tid(res_tid),
    .outstanding(outstanding), .busy(busy), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  // Core model: 20-cycle latency, results parked while hold is set.
  typedef struct { int due; logic [23:0] val; } core_t;
  core_t core_q[$];
  int    cyc = 0;
  int    rel_req = 0;
  int    rel_done = 0;
  bit    hold = 1'b0;
  bit    inj  = 1'b0;

  function automatic logic [23:0] isqrt(input logic [47:0] x);
    longint unsigned v, r, b;
    v = 64'(x); r = 0; b = 64'd1 << 46;
    while (b > v) b = b >> 2;
    while (b != 0) begin
      if (v >= r + b) begin v = v - (r + b); r = (r >> 1) + b; end
      else r = r >> 1;
      b = b >> 2;
    end
    return 24'(r);
  endfunction

  always @(posedge clk) begin
    if (sqrt_in_tvalid) core_q.push_back('{cyc + 20, isqrt(sqrt_in_tdata)});
    if (core_q.size() > 0 && core_q[0].due <= cyc + 1 && (!hold || rel_done < rel_req)) begin
      sqrt_out_tvalid <= 1'b1;
      sqrt_out_tdata  <= core_q[0].val;
      void'(core_q.pop_front());
      if (hold) rel_done <= rel_done + 1;
    end else begin
      sqrt_out_tvalid <= inj;
      sqrt_out_tdata  <= 24'hABCDEF;
    end
    cyc <= cyc + 1;
  end

  // Scoreboard
  typedef struct { logic [1:0] tid; logic [23:0] val; int due; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input int max);
    int w;
    w = 0;
    while ((outstanding != 6'd0 || exp_q.size() != 0) && w < max) begin
      tick(); w++;
    end
    chk("drain_outstanding_and_queue", {outstanding, 1'(exp_q.size() != 0)}, '0);
  endtask

  // Hand-computed operand/root pairs for the alternating test
  logic [47:0] OPS_A  [4] = '{48'd100, 48'd400, 48'd900, 48'd1600};
  logic [23:0] ROOT_A [4] = '{24'd10, 24'd20, 24'd30, 24'd40};
  logic [47:0] OPS_B  [4] = '{48'd49, 48'd144, 48'd10000, 48'd1000000000000};
  logic [23:0] ROOT_B [4] = '{24'd7, 24'd12, 24'd100, 24'd1000000};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, a, b, k, issues, outs;
    rst_n = 1'b0; req_tvalid = '0; req_tdata = '0;

    fork
      forever begin
        @(posedge clk); #1;
        if (res_tvalid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got tid=%0d data=%0d, required no result", res_tid, res_tdata);
          end else begin
            mon_e = exp_q.pop_front();
            if (res_tid !== mon_e.tid || res_tdata !== mon_e.val || (mon_e.due >= 0 && cyc != mon_e.due)) begin
              errors++;
              $display("FAIL result: got tid=%0d data=%0d cycle=%0d, required tid=%0d data=%0d cycle=%0d",
                       res_tid, res_tdata, cyc, mon_e.tid, mon_e.val, mon_e.due);
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {req_tready, sqrt_in_tvalid, res_tvalid, res_tid, outstanding, err_orphan, busy},
        {2'b00, 1'b0, 1'b0, 2'b00, 6'd0, 1'b0, 1'b1});
    chk("reset_data", {sqrt_in_tdata, res_tdata}, '0);

    // Flush after release: busy for 20 cycles, stale core output ignored
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 40) begin
      n++;
      inj = (n == 10);
      tick();
    end
    inj = 1'b0;
    chk("flush_busy_cycles", n, 20);
    chk("flush_no_orphan", err_orphan, 0);

    // Two requesters continuously valid: grants alternate, req0 first
    a = 0; b = 0;
    for (int t = 0; t < 8; t++) begin
      req_tvalid = 2'b11;
      req_tdata  = {OPS_B[b], OPS_A[a]};
      #1;
      chk("rr_grant", req_tready, (t % 2 == 0) ? 2'b01 : 2'b10);
      if (req_tready[0]) begin exp_q.push_back('{2'd0, ROOT_A[a], cyc + 22}); a++; end
      else if (req_tready[1]) begin exp_q.push_back('{2'd1, ROOT_B[b], cyc + 22}); b++; end
      if (a > 3) a = 3;
      if (b > 3) b = 3;
      tick();
    end
    req_tvalid = '0;
    wait_drain(60);

    // Single request, latency SQRT_LATENCY+2
    req_tvalid = 2'b01;
    req_tdata[47:0] = 48'd1000000;
    #1;
    chk("single_ready", req_tready, 2'b01);
    exp_q.push_back('{2'd0, 24'd1000, cyc + 22});
    tick();
    req_tvalid = '0;
    chk("single_issue", {sqrt_in_tvalid, sqrt_in_tdata}, {1'b1, 48'd1000000});
    chk("single_outstanding", outstanding, 1);
    tick();
    chk("issue_data_hold", {sqrt_in_tvalid, sqrt_in_tdata}, {1'b0, 48'd1000000});
    wait_drain(40);

    // Core held off: 32 issues then full; one return frees one slot next cycle
    hold = 1'b1; k = 0; issues = 0;
    req_tvalid = 2'b10;
    for (int t = 0; t < 40; t++) begin
      req_tdata[95:48] = 48'((k + 1) * (k + 1));
      #1;
      if (req_tready[1]) begin
        exp_q.push_back('{2'd1, 24'(k + 1), -1});
        issues++; k++;
      end
      tick();
    end
    req_tdata[95:48] = 48'((k + 1) * (k + 1));
    #1;
    chk("full_issues", issues, 32);
    chk("full_outstanding", outstanding, 32);
    chk("full_ready", req_tready, 2'b00);
    rel_req = rel_req + 1;
    tick(); #1;
    chk("pop_same_cycle_ready", req_tready, 2'b00);
    chk("pop_same_cycle_outstanding", outstanding, 32);
    tick(); #1;
    chk("pop_next_cycle_ready", req_tready, 2'b10);
    chk("pop_next_cycle_outstanding", outstanding, 31);
    if (req_tready[1]) exp_q.push_back('{2'd1, 24'(k + 1), -1});
    tick();
    req_tvalid = '0;
    hold = 1'b0;
    wait_drain(120);

    // Orphan result in RUN
    chk("pre_orphan", {outstanding, err_orphan}, '0);
    inj = 1'b1;
    tick();
    inj = 1'b0;
    tick(); tick();
    chk("orphan_set", err_orphan, 1);
    repeat (5) tick();
    chk("orphan_sticky", err_orphan, 1);

    // Reset with 5 outstanding
    req_tvalid = 2'b01;
    req_tdata[47:0] = 48'd36;
    issues = 0;
    for (int t = 0; t < 5; t++) begin
      #1;
      if (req_tready[0]) begin exp_q.push_back('{2'd0, 24'd6, cyc + 22}); issues++; end
      tick();
    end
    req_tvalid = '0;
    tick();
    chk("stream_issues", issues, 5);
    chk("pre_reset_outstanding", outstanding, 5);
    rst_n = 1'b0;
    #1;
    chk("midreset_ctrl", {req_tready, sqrt_in_tvalid, res_tvalid, outstanding, err_orphan, busy},
        {2'b00, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1});
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    n = 0; outs = 0;
    while (busy && n < 40) begin
      n++;
      if (sqrt_out_tvalid) outs++;
      tick();
    end
    chk("reflush_busy_cycles", n, 20);
    chk("flush_dropped_results", outs, 5);
    chk("reflush_no_orphan", {err_orphan, outstanding}, '0);

    // Normal request after reset
    req_tvalid = 2'b10;
    req_tdata[95:48] = 48'd1000000;
    #1;
    chk("post_reset_ready", req_tready, 2'b10);
    exp_q.push_back('{2'd1, 24'd1000, cyc + 22});
    tick();
    req_tvalid = '0;
    wait_drain(40);
    chk("final_err_orphan", err_orphan, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sqrt_arbiter.md
Name: sqrt_arbiter

Overview:
- Shares one pipelined square-root core (48-bit in, 24-bit out, fixed latency, no backpressure, no sideband) among NUM_REQ requesters.
- Typical requesters: the spectrum-norm accumulator and per-band energy accumulators.
- Grants round-robin, forwards the winning operand to the core, and tags each issue with the requester ID in an internal FIFO.
- Returns each result with its ID, in issue order.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- IN_W, 48, operand width into the core.
- OUT_W, 24, result width from the core.
- SQRT_LATENCY, 20, core latency in cycles from input tvalid to output tvalid.
- MAX_OUTSTANDING, 32, tag FIFO depth (power of two, >= SQRT_LATENCY+2).

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_tvalid  in  NUM_REQ  per-requester operand valid.
- req_tdata  in  NUM_REQ*IN_W  packed operands; requester i occupies bits [i*IN_W +: IN_W].
- req_tready  out  NUM_REQ  per-requester accept (one-hot or zero).
- sqrt_in_tvalid  out  1  to core s_axis_cartesian_tvalid.
- sqrt_in_tdata  out  IN_W  to core s_axis_cartesian_tdata.
- sqrt_out_tvalid  in  1  from core m_axis_dout_tvalid.
- sqrt_out_tdata  in  OUT_W  from core m_axis_dout_tdata.
- res_tvalid  out  1  result valid, single-cycle pulse, no backpressure.
- res_tdata  out  OUT_W  result.
- res_tid  out  2  requester index of the result.
- outstanding  out  6  issued results not yet returned.
- busy  out  1  high in FLUSH or when outstanding != 0.
- err_orphan  out  1  sticky; core produced a result with the tag FIFO empty during RUN.

Behaviour:
- Reset (async assert, sync release):
  - req_tready=0, sqrt_in_tvalid=0, sqrt_in_tdata=0, res_tvalid=0, res_tdata=0, res_tid=0, outstanding=0, err_orphan=0.
  - Tag FIFO empty; last_grant=NUM_REQ-1; state=FLUSH; flush_cnt=SQRT_LATENCY.
- State FLUSH:
  - The core pipeline is not reset, so the arbiter drains it.
  - req_tready=0; sqrt_out_tvalid is ignored (no res, no error).
  - flush_cnt decrements each cycle; at 0 -> RUN. busy=1.
- State RUN, arbitration:
  - Combinational; search order starts at last_grant+1 and wraps.
  - Grant the first i with req_tvalid[i]=1, provided count_pre < MAX_OUTSTANDING.
  - count_pre is the registered occupancy. A pop in the same cycle does NOT free a slot for that cycle's grant.
  - req_tready[i]=grant[i]; at most one bit is set.
  - Handshake = req_tvalid[i] & req_tready[i].
- Issue:
  - On handshake, next edge: sqrt_in_tvalid=1, sqrt_in_tdata=req_tdata slice i, push tag i, last_grant=i.
  - Otherwise sqrt_in_tvalid=0 and sqrt_in_tdata holds its value.
  - One issue per cycle max; a single continuously-valid requester gets every cycle.
- Return:
  - On sqrt_out_tvalid in RUN with FIFO non-empty: pop tag.
  - Next edge: res_tvalid=1, res_tdata=sqrt_out_tdata, res_tid=popped tag.
  - Total latency, handshake to res_tvalid = SQRT_LATENCY+2 cycles.
- Orphan: sqrt_out_tvalid in RUN with FIFO empty -> err_orphan=1 (held until reset), result dropped, res_tvalid=0.
- Occupancy:
  - Push and pop in the same cycle: outstanding unchanged, both performed.
  - outstanding = FIFO count; FIFO pointers wrap modulo MAX_OUTSTANDING.
- Full: with count_pre=MAX_OUTSTANDING, all req_tready=0 and requesters hold req_tvalid/req_tdata stable (AXI-stream rule).
- Requester dropping tvalid without handshake: legal; arbitration re-evaluates each cycle.
- Reset mid-operation:
  - All in-flight tags are lost; returns to FLUSH.
  - Core results still in flight emerge during FLUSH and are discarded without error.
- Widths: NUM_REQ>4 is unsupported (res_tid is 2 bits); outstanding is 6 bits (supports MAX_OUTSTANDING<=32).

Test Plan:
- Reset release, no requests: busy=1 for exactly 20 cycles, then 0; inject sqrt_out_tvalid at cycle 10 -> no res_tvalid, err_orphan stays 0.
- Single request: req0 operand 48'd1_000_000 at cycle 30 -> sqrt_in_tvalid at 31 with that data; model core returns 1000 -> res_tvalid at cycle 52 with res_tdata=1000, res_tid=0; outstanding 1 -> 0.
- Both requesters valid continuously for 8 cycles -> grants alternate 0,1,0,1... (req0 first after reset); results return in same order with matching res_tid.
- Model core held off (no outputs) with req1 always valid -> exactly 32 issues, then req_tready=0 while outstanding=32; one return restores one grant on the following cycle, not the same cycle.
- In RUN, pulse sqrt_out_tvalid with outstanding=0 -> err_orphan=1 and stays 1; no res_tvalid.
- Assert rst_n low with 5 outstanding, release: outstanding=0, 5 in-flight core outputs arrive during FLUSH and are dropped, err_orphan=0, next request completes normally.
